// File: rtl/sha1_pkg.sv
// Shared SHA-1 schedule constants and the sequencer state encoding.
package sha1_pkg;

  localparam int unsigned SHA1_ROUNDS  = 80;
  localparam int unsigned SHA1_PRELOAD = 16;
  localparam int unsigned SHA1_IDX_W   = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrlState_t;

endpackage

// File: rtl/wengine_round_cnt.sv
// Round index counter for the message-schedule sequencer.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc        : advance the index by one
//   clear      : return the index to 0 (wins over inc)
//   count      : current round index
//   isLast     : count == ROUNDS-1
//   inRecur    : count >= PRELOAD-1, i.e. the next advance needs the recurrence
module wengine_round_cnt
  import sha1_pkg::*;
#(
  parameter int unsigned ROUNDS  = SHA1_ROUNDS,
  parameter int unsigned PRELOAD = SHA1_PRELOAD,
  parameter int unsigned IDX_W   = SHA1_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [IDX_W-1:0] count,
  output logic             isLast,
  output logic             inRecur
);

  // Index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + IDX_W'(1);
    end
  end

  assign isLast  = (count == IDX_W'(ROUNDS - 1));
  assign inRecur = (count >= IDX_W'(PRELOAD - 1));

endmodule

// File: rtl/wengine_ctrl.sv
// Block-level sequencer for the 16-word SHA-1 message-schedule engine.
// Accepts 512-bit blocks over blk_valid/blk_ready, then presents
// W0..W(ROUNDS-1) one per w_valid/w_ready handshake while steering the
// engine's feed/next/stage controls.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   blk_valid/blk_ready : upstream block handshake
//   w_valid/w_ready     : downstream word handshake
//   round               : index of the word currently on the engine output
//   feed, next, stage   : engine controls (load block / advance / recurrence)
//   busy                : block in progress
//   blk_done            : pulse when the last word is consumed
module wengine_ctrl
  import sha1_pkg::*;
#(
  parameter int unsigned ROUNDS  = SHA1_ROUNDS,
  parameter int unsigned PRELOAD = SHA1_PRELOAD,
  parameter int unsigned IDX_W   = SHA1_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [IDX_W-1:0] round,
  output logic             feed,
  output logic             next,
  output logic             stage,
  output logic             busy,
  output logic             blk_done
);

  ctrlState_t state;
  logic       fire;
  logic       lastFire;
  logic       isLast;
  logic       inRecur;

  // Handshake decode; a word is only offered while running.
  assign fire     = (state == RUN) && w_ready;
  assign lastFire = fire && isLast;

  // Upstream may hand over the next block on the same cycle the last word
  // leaves, which gives back-to-back blocks with no idle cycle.
  assign blk_ready = (state == IDLE) || lastFire;
  assign feed      = blk_valid && blk_ready;
  assign next      = fire && !isLast;
  assign stage     = next && inRecur;
  assign blk_done  = lastFire;

  assign w_valid = (state == RUN);
  assign busy    = (state == RUN);

  wengine_round_cnt #(
    .ROUNDS (ROUNDS),
    .PRELOAD(PRELOAD),
    .IDX_W  (IDX_W)
  ) u_roundCnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (next),
    .clear  (lastFire),
    .count  (round),
    .isLast (isLast),
    .inRecur(inRecur)
  );

  // Sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (blk_valid) begin
        state <= RUN;
      end
    end else if (lastFire && !blk_valid) begin
      state <= IDLE;
    end
  end

endmodule
